stream_mux_nto1: RTL



---
 rtl/stream_mux_nto1.sv | 117 +++++++++++
 1 files changed

// File: rtl/stream_mux_nto1.sv
// N-to-1 valid/ready stream mux with fixed-select or round-robin grant and one registered output stage.
// One cycle of latency; a held word that is not consumed blocks every input until out_ready rises.
module stream_mux_nto1 #(
   parameter int WIDTH = 16,
   parameter int N     = 4,
   parameter int SELW  = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_chan,
   output logic                 out_valid,
   input  logic                 out_ready
);

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SELW-1:0]  out_chan_q, out_chan_d;
   logic             out_valid_q, out_valid_d;
   logic [SELW-1:0]  rr_last_q, rr_last_d;

   logic             load;
   logic             grant_vld;
   logic [SELW-1:0]  grant_idx;
   logic             hi_vld, lo_vld;
   logic [SELW-1:0]  hi_idx, lo_idx;
   logic [WIDTH-1:0] grant_data;

   assign load = !out_valid_q || out_ready;

   // Round-robin: lowest valid channel above rr_last wins, else lowest at or below it (wrap).
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      hi_vld    = 1'b0;
      lo_vld    = 1'b0;
      hi_idx    = '0;
      lo_idx    = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (in_valid[i]) begin
            if (SELW'(i) > rr_last_q) begin
               hi_vld = 1'b1;
               hi_idx = SELW'(i);
            end else begin
               lo_vld = 1'b1;
               lo_idx = SELW'(i);
            end
         end
      end
      if (mode) begin
         if (hi_vld) begin
            grant_vld = 1'b1;
            grant_idx = hi_idx;
         end else if (lo_vld) begin
            grant_vld = 1'b1;
            grant_idx = lo_idx;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (sel == SELW'(i) && in_valid[i]) begin
               grant_vld = 1'b1;
               grant_idx = SELW'(i);
            end
         end
      end
   end

   always_comb begin
      grant_data  = '0;
      in_ready    = '0;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      out_valid_d = out_valid_q;
      rr_last_d   = rr_last_q;
      for (int i = 0; i < N; i++) begin
         if (grant_idx == SELW'(i)) begin
            grant_data = in_data[i*WIDTH +: WIDTH];
            in_ready[i] = load && grant_vld && !reset;
         end
      end
      if (load) begin
         if (grant_vld) begin
            out_data_d  = grant_data;
            out_chan_d  = grant_idx;
            out_valid_d = 1'b1;
            if (mode) begin
               rr_last_d = grant_idx;
            end
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_data_q  <= '0;
         out_chan_q  <= '0;
         out_valid_q <= 1'b0;
         rr_last_q   <= SELW'(N - 1);
      end else begin
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         out_valid_q <= out_valid_d;
         rr_last_q   <= rr_last_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;
   assign out_valid = out_valid_q;

endmodule
